// File: rtl/mem_pkg.sv
// mem_pkg: shared frame-buffer block geometry and footer layout for writer and reader
package mem_pkg;

    localparam int ADDR_W     = 8;
    localparam int FOOTER_W   = 16;
    localparam int BLOCK_BITS = 48;
    localparam int PAY_W      = BLOCK_BITS - FOOTER_W;

    typedef struct packed {
        logic                       eop;
        logic [FOOTER_W-2-ADDR_W:0] rsvd;
        logic [ADDR_W-1:0]          next_idx;
    } footer_t;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_e;

    // The last block of a chain carries eop and a zero link
    function automatic footer_t make_footer(input logic eop, input logic [ADDR_W-1:0] next_idx);
        footer_t f;
        f.eop      = eop;
        f.rsvd     = '0;
        f.next_idx = eop ? '0 : next_idx;
        return f;
    endfunction

endpackage

// File: rtl/mem_prefetch_slots.sv
// mem_prefetch_slots: two-entry buffer of prefetched free-block indices (cur, nxt)
module mem_prefetch_slots #(
    parameter int ADDR_W = mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_idx_i,
    input  logic              shift_i,
    output logic [ADDR_W-1:0] cur_o,
    output logic [ADDR_W-1:0] nxt_o,
    output logic [1:0]        count_o
);

    logic [ADDR_W-1:0] cur_q, cur_d, nxt_q, nxt_d;
    logic              cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;

    assign cur_o   = cur_q;
    assign nxt_o   = nxt_q;
    assign count_o = {cur_v_q & nxt_v_q, cur_v_q ^ nxt_v_q};

    // Shift on consume (refilling nxt from a same-cycle grant); otherwise fill the empty slot, cur first
    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cur_v_d = cur_v_q;
        nxt_v_d = nxt_v_q;
        if (shift_i) begin
            cur_d   = nxt_q;
            cur_v_d = nxt_v_q;
            nxt_d   = fill_i ? fill_idx_i : nxt_q;
            nxt_v_d = fill_i;
        end else if (fill_i) begin
            if (!cur_v_q) begin
                cur_d   = fill_idx_i;
                cur_v_d = 1'b1;
            end else begin
                nxt_d   = fill_idx_i;
                nxt_v_d = 1'b1;
            end
        end
    end

    // Slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            nxt_q   <= '0;
            cur_v_q <= 1'b0;
            nxt_v_q <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            cur_v_q <= cur_v_d;
            nxt_v_q <= nxt_v_d;
        end
    end

endmodule

// File: rtl/memory_write_ctrl.sv
// memory_write_ctrl: ingress linked-list writer, one payload beat per block, chained via footers
module memory_write_ctrl #(
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
    localparam int PAY_W     = BLOCK_BITS - mem_pkg::FOOTER_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PAY_W-1:0]      data_i,
    input  logic                  data_valid_i,
    input  logic                  data_last_i,
    output logic                  ready_o,
    output logic                  alloc_req_o,
    input  logic                  alloc_gnt_i,
    input  logic [ADDR_W-1:0]     alloc_idx_i,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_waddr_o,
    output logic [BLOCK_BITS-1:0] mem_wdata_o,
    output logic                  frame_done_o,
    output logic [ADDR_W-1:0]     frame_head_o,
    output logic [ADDR_W:0]       frame_nblk_o
);

    import mem_pkg::frame_state_e;
    import mem_pkg::IDLE;
    import mem_pkg::IN_FRAME;
    import mem_pkg::make_footer;

    localparam logic [ADDR_W:0] NBLK_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] NBLK_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic              accept, fill;
    logic [ADDR_W-1:0] cur, nxt;
    logic [1:0]        slot_cnt;

    frame_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     head_q, head_d;
    logic [ADDR_W:0]       nblk_q, nblk_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic [ADDR_W-1:0]     frame_head_q, frame_head_d;
    logic [ADDR_W:0]       frame_nblk_q, frame_nblk_d;

    // Ready only when both cur and its successor are known, so a non-last beat always has its link.
    // The request is held low during reset so every output reads 0 while rst_n is asserted.
    assign ready_o     = (slot_cnt == 2'd2);
    assign accept      = data_valid_i & ready_o;
    assign alloc_req_o = rst_n & (!ready_o | accept);
    assign fill        = alloc_gnt_i & alloc_req_o;

    mem_prefetch_slots #(.ADDR_W(ADDR_W)) u_slots (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_i     (fill),
        .fill_idx_i (alloc_idx_i),
        .shift_i    (accept),
        .cur_o      (cur),
        .nxt_o      (nxt),
        .count_o    (slot_cnt)
    );

    // Next-state: block write stage, frame tracking, and the held frame report
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        nblk_d       = nblk_q;
        we_d         = accept;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        done_d       = accept & data_last_i;
        frame_head_d = frame_head_q;
        frame_nblk_d = frame_nblk_q;
        if (accept) begin
            waddr_d = cur;
            wdata_d = {data_i, make_footer(data_last_i, nxt)};
            head_d  = (state_q == IDLE) ? cur : head_q;
            nblk_d  = (state_q == IDLE) ? NBLK_ONE
                    : (nblk_q == NBLK_MAX) ? nblk_q : nblk_q + NBLK_ONE;
            state_d = data_last_i ? IDLE : IN_FRAME;
        end
        if (done_d) begin
            frame_head_d = head_d;
            frame_nblk_d = nblk_d;
        end
    end

    // Frame FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            head_q       <= '0;
            nblk_q       <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            frame_head_q <= '0;
            frame_nblk_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            nblk_q       <= nblk_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            frame_head_q <= frame_head_d;
            frame_nblk_q <= frame_nblk_d;
        end
    end

    assign mem_we_o     = we_q;
    assign mem_waddr_o  = waddr_q;
    assign mem_wdata_o  = wdata_q;
    assign frame_done_o = done_q;
    assign frame_head_o = frame_head_q;
    assign frame_nblk_o = frame_nblk_q;

    // A grant nobody asked for would be lost by the free list
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n) alloc_gnt_i |-> alloc_req_o);

    // The block count cannot legitimately exceed the memory size
    a_nblk_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (accept && state_q == IN_FRAME) |-> nblk_q != NBLK_MAX);

endmodule

// File: tb/tb_memory_write_ctrl.sv
// tb_memory_write_ctrl: directed table, corner sequences and random traffic against a queue model
module tb_memory_write_ctrl;

    localparam int ADDR_W     = mem_pkg::ADDR_W;
    localparam int BLOCK_BITS = mem_pkg::BLOCK_BITS;
    localparam int PAY_W      = BLOCK_BITS - mem_pkg::FOOTER_W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [PAY_W-1:0]      data_i = '0;
    logic                  data_valid_i = 1'b0;
    logic                  data_last_i = 1'b0;
    logic                  ready_o;
    logic                  alloc_req_o;
    logic                  alloc_gnt_i = 1'b0;
    logic [ADDR_W-1:0]     alloc_idx_i = '0;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_waddr_o;
    logic [BLOCK_BITS-1:0] mem_wdata_o;
    logic                  frame_done_o;
    logic [ADDR_W-1:0]     frame_head_o;
    logic [ADDR_W:0]       frame_nblk_o;

    memory_write_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_last_i  (data_last_i),
        .ready_o      (ready_o),
        .alloc_req_o  (alloc_req_o),
        .alloc_gnt_i  (alloc_gnt_i),
        .alloc_idx_i  (alloc_idx_i),
        .mem_we_o     (mem_we_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .frame_done_o (frame_done_o),
        .frame_head_o (frame_head_o),
        .frame_nblk_o (frame_nblk_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: prefetched indices in fill order, blocks of the open frame, held frame report
    int slots[$];
    int frame[$];
    int e_head = 0;
    int e_nblk = 0;

    logic acc;

    typedef struct {
        logic       rst;
        logic       v;
        logic       l;
        logic       g;
        logic [7:0] gi;
        logic       e_ready;
        logic       e_we;
        logic [7:0] e_addr;
        logic       e_eop;
        logic [7:0] e_next;
        logic       e_done;
        logic [7:0] e_head;
        int         e_nblk;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock edge
    task automatic reset_dut();
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        alloc_gnt_i  = 1'b0;
        rst_n        = 1'b0;
        slots.delete();
        frame.delete();
        e_head = 0;
        e_nblk = 0;
        #1;
        chk("rst_we",    64'(mem_we_o), 64'(0));
        chk("rst_waddr", 64'(mem_waddr_o), 64'(0));
        chk("rst_wdata", 64'(mem_wdata_o), 64'(0));
        chk("rst_done",  64'(frame_done_o), 64'(0));
        chk("rst_head",  64'(frame_head_o), 64'(0));
        chk("rst_nblk",  64'(frame_nblk_o), 64'(0));
        chk("rst_ready", 64'(ready_o), 64'(0));
        chk("rst_req",   64'(alloc_req_o), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, check combinational handshake, advance model, check registered outputs
    task automatic cycle(input logic v, input logic l, input logic [PAY_W-1:0] d,
                         input logic g, input logic [ADDR_W-1:0] gi, output logic accepted);
        logic rdy, req, gh, e_we;
        logic [15:0] foot;
        logic [BLOCK_BITS-1:0] e_wdata;
        logic [ADDR_W-1:0] e_addr;
        rdy = (slots.size() == 2);
        accepted = v & rdy;
        req = !rdy | accepted;
        gh = g & req;
        data_valid_i = v;
        data_last_i  = l;
        data_i       = d;
        alloc_gnt_i  = gh;
        alloc_idx_i  = gi;
        e_we = accepted;
        e_addr = '0;
        e_wdata = '0;
        #1;
        chk("ready", 64'(ready_o), 64'(rdy));
        chk("alloc_req", 64'(alloc_req_o), 64'(req));
        if (accepted) begin
            e_addr = ADDR_W'(slots[0]);
            foot = l ? 16'h8000 : 16'(slots[1]);
            e_wdata = {d, foot};
            frame.push_back(slots[0]);
            if (l) begin
                e_head = frame[0];
                e_nblk = frame.size();
                frame.delete();
            end
            void'(slots.pop_front());
        end
        if (gh) slots.push_back(int'(gi));
        @(posedge clk);
        #1;
        chk("we", 64'(mem_we_o), 64'(e_we));
        chk("done", 64'(frame_done_o), 64'(accepted & l));
        chk("head", 64'(frame_head_o), 64'(e_head));
        chk("nblk", 64'(frame_nblk_o), 64'(e_nblk));
        if (e_we) begin
            chk("waddr", 64'(mem_waddr_o), 64'(e_addr));
            chk("wdata", 64'(mem_wdata_o), 64'(e_wdata));
        end
    endtask

    initial begin
        logic pv, pl;
        logic [PAY_W-1:0] pd;

        tbl[0] = '{1, 0, 0, 1,  5,  0, 0,  0, 0,  0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 1,  9,  1, 0,  0, 0,  0, 0, 0, 0};
        tbl[2] = '{0, 1, 1, 0,  0,  0, 1,  5, 1,  0, 1, 5, 1};
        tbl[3] = '{1, 0, 0, 1,  5,  0, 0,  0, 0,  0, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 1,  9,  1, 0,  0, 0,  0, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 1, 12,  1, 1,  5, 0,  9, 0, 0, 0};
        tbl[6] = '{0, 1, 0, 1,  3,  1, 1,  9, 0, 12, 0, 0, 0};
        tbl[7] = '{0, 1, 1, 0,  0,  0, 1, 12, 1,  0, 1, 5, 3};

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst) reset_dut();
            cycle(tbl[i].v, tbl[i].l, PAY_W'(32'hA000_0000 + i), tbl[i].g, tbl[i].gi, acc);
            chk($sformatf("tbl%0d_ready", i), 64'(ready_o), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_we", i), 64'(mem_we_o), 64'(tbl[i].e_we));
            chk($sformatf("tbl%0d_done", i), 64'(frame_done_o), 64'(tbl[i].e_done));
            chk($sformatf("tbl%0d_head", i), 64'(frame_head_o), 64'(tbl[i].e_head));
            chk($sformatf("tbl%0d_nblk", i), 64'(frame_nblk_o), 64'(tbl[i].e_nblk));
            if (tbl[i].e_we) begin
                chk($sformatf("tbl%0d_addr", i), 64'(mem_waddr_o), 64'(tbl[i].e_addr));
                chk($sformatf("tbl%0d_eop", i), 64'(mem_wdata_o[15]), 64'(tbl[i].e_eop));
                chk($sformatf("tbl%0d_next", i), 64'(mem_wdata_o[7:0]), 64'(tbl[i].e_next));
                chk($sformatf("tbl%0d_data", i), 64'(mem_wdata_o[BLOCK_BITS-1:16]), 64'(32'hA000_0000 + i));
            end
        end

        // Mid-frame free-list starvation: slots [3] -> [3,40], one beat, then 10 grant-less cycles
        cycle(0, 0, '0, 1, 8'd40, acc);
        cycle(1, 0, PAY_W'(32'h5151_0000), 0, '0, acc);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, PAY_W'(32'h5151_0001), 0, '0, acc);
            chk("stall_ready", 64'(ready_o), 64'(0));
            chk("stall_we", 64'(mem_we_o), 64'(0));
        end
        cycle(1, 1, PAY_W'(32'h5151_0001), 1, 8'd41, acc);
        chk("stall_not_accepted", 64'(acc), 64'(0));
        cycle(1, 1, PAY_W'(32'h5151_0001), 0, '0, acc);
        chk("stall_done", 64'(frame_done_o), 64'(1));
        chk("stall_head", 64'(frame_head_o), 64'(3));
        chk("stall_nblk", 64'(frame_nblk_o), 64'(2));
        chk("stall_addr", 64'(mem_waddr_o), 64'(40));

        // Back-to-back frames A (2 blocks) and B (1 block) with a grant every cycle
        cycle(0, 0, '0, 1, 8'd50, acc);
        cycle(1, 0, PAY_W'(32'hAAAA_0000), 1, 8'd51, acc);
        chk("b2b_a0_acc", 64'(acc), 64'(1));
        cycle(1, 1, PAY_W'(32'hAAAA_0001), 1, 8'd52, acc);
        chk("b2b_a1_acc", 64'(acc), 64'(1));
        chk("b2b_a_done", 64'(frame_done_o), 64'(1));
        chk("b2b_a_head", 64'(frame_head_o), 64'(41));
        chk("b2b_a_nblk", 64'(frame_nblk_o), 64'(2));
        cycle(1, 1, PAY_W'(32'hBBBB_0000), 1, 8'd53, acc);
        chk("b2b_b_acc", 64'(acc), 64'(1));
        chk("b2b_b_we", 64'(mem_we_o), 64'(1));
        chk("b2b_b_done", 64'(frame_done_o), 64'(1));
        chk("b2b_b_head", 64'(frame_head_o), 64'(51));
        chk("b2b_b_nblk", 64'(frame_nblk_o), 64'(1));

        // Reset in the middle of a frame while a write is on the outputs
        cycle(1, 0, PAY_W'(32'hCCCC_0000), 1, 8'd60, acc);
        reset_dut();
        cycle(0, 0, '0, 1, 8'd70, acc);
        cycle(0, 0, '0, 1, 8'd71, acc);
        cycle(1, 1, PAY_W'(32'hDDDD_0000), 0, '0, acc);
        chk("post_rst_done", 64'(frame_done_o), 64'(1));
        chk("post_rst_head", 64'(frame_head_o), 64'(70));
        chk("post_rst_nblk", 64'(frame_nblk_o), 64'(1));

        // Random traffic; a producer holds its beat until accepted
        pv = 1'b0;
        pl = 1'b0;
        pd = '0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) reset_dut();
            if (!pv && $urandom_range(0, 9) < 7) begin
                pv = 1'b1;
                pl = ($urandom_range(0, 3) == 0);
                pd = PAY_W'($urandom);
            end
            cycle(pv, pl, pd, $urandom_range(0, 9) < 6, ADDR_W'($urandom_range(0, 255)), acc);
            if (acc) pv = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
